// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and helpers for the data-memory port arbiter
// Contents:
//   state_t  - FSM states (ST_IDLE, ST_RD_WAIT)
//   owner_t  - transaction owner (OWN_CPU, OWN_EXT)
//   lat_init - starting value of the read latency counter for a given RD_LAT
package mem_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    function automatic logic [1:0] lat_init(input int rd_lat);
        return (rd_lat == 0) ? 2'd0 : 2'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a registered last-grant pointer
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   req[1:0]    - requests (bit 0 = CPU, bit 1 = EXT)
//   advance     - a grant was taken this cycle; update last_grant
//   gnt[1:0]    - one-hot grant
//   last_grant  - owner of the most recent accepted grant (EXT after reset)
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output owner_t     last_grant
);

    // On a tie the requester that did not win last time gets the port.
    assign gnt[0] = req[0] & (~req[1] | (last_grant == OWN_EXT));
    assign gnt[1] = req[1] & (~req[0] | (last_grant == OWN_CPU));

    always_ff @(posedge clk or posedge rst)
        if (rst)
            last_grant <= OWN_EXT;
        else if (advance)
            last_grant <= gnt[1] ? OWN_EXT : OWN_CPU;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the data-memory port between the CPU MEM stage and an external master
// Ports:
//   clk, rst                               - clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_rdata       - MEM stage access; cpu_stall freezes the pipeline
//   ext_req/we/addr/wdata                  - external master request, held until ext_ack
//   ext_ack, ext_rvalid, ext_rdata         - accept pulse, read-data pulse and data
//   mem_we/addr/wdata, mem_rdata           - DRAM macro interface
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] LAT_INIT = lat_init(RD_LAT);

    state_t        state, state_nx;
    owner_t        owner_q, last_grant;
    logic [AW-1:0] addr_q, win_addr;
    logic [DW-1:0] win_wdata;
    logic [1:0]    lat_cnt, gnt;
    logic          accept, win_ext, win_we, ret, ret_ext, cpu_done;

    // Arbitration only happens in IDLE, so a request arriving in the return
    // cycle of a read waits for the next IDLE cycle.
    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        ({ext_req, cpu_req} & {2{(state == ST_IDLE) && !rst}}),
        .advance    (accept),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    assign accept    = |gnt;
    assign win_ext   = gnt[1];
    assign win_we    = win_ext ? ext_we : cpu_we;
    assign win_addr  = win_ext ? ext_addr : cpu_addr;
    assign win_wdata = win_ext ? ext_wdata : cpu_wdata;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= ST_IDLE;
            owner_q <= OWN_CPU;
            addr_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                owner_q <= owner_t'(win_ext);
                addr_q  <= win_addr;
            end
        end

    generate
        if (RD_LAT == 0) begin : g_no_lat
            assign lat_cnt = 2'd0;
        end else begin : g_lat
            always_ff @(posedge clk or posedge rst)
                if (rst)
                    lat_cnt <= 2'd0;
                else if (accept)
                    lat_cnt <= LAT_INIT;
                else if (state == ST_RD_WAIT && lat_cnt != 2'd0)
                    lat_cnt <= lat_cnt - 2'd1;
        end
    endgenerate

    always_comb begin
        state_nx = state;
        if (state == ST_IDLE)
            state_nx = (accept && !win_we && RD_LAT != 0) ? ST_RD_WAIT : ST_IDLE;
        else
            state_nx = (lat_cnt == 2'd0) ? ST_IDLE : ST_RD_WAIT;
    end

    always_comb begin
        // With RD_LAT=0 reads return in the accept cycle, straight from the winner.
        ret        = (RD_LAT == 0) ? (accept && !win_we) : (state == ST_RD_WAIT && lat_cnt == 2'd0);
        ret_ext    = (RD_LAT == 0) ? win_ext : (owner_q == OWN_EXT);
        cpu_done   = (gnt[0] & cpu_we) | (ret & ~ret_ext);
        cpu_stall  = cpu_req & ~rst & ~cpu_done;
        cpu_rdata  = (ret && !ret_ext && cpu_req) ? mem_rdata : '0;
        ext_ack    = gnt[1];
        ext_rvalid = ret & ret_ext;
        ext_rdata  = ext_rvalid ? mem_rdata : '0;
        mem_we     = accept & win_we;
        mem_addr   = (state == ST_RD_WAIT) ? addr_q : (accept ? win_addr : '0);
        mem_wdata  = (accept && win_we) ? win_wdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with RD_LAT=1
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, ext_ack, ext_rvalid, mem_we;
    logic [31:0] dram [0:255];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_ack    (ext_ack),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // One-cycle synchronous DRAM model
    always @(posedge clk) begin
        if (mem_we)
            dram[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= dram[mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic ext(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ext_req = r; ext_we = w; ext_addr = a; ext_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        cpu(0, 0, 0, 0);
        ext(0, 0, 0, 0);
        @(negedge clk); #1;
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ext_ack", 32'(ext_ack), 0);
        chk("rst_ext_rvalid", 32'(ext_rvalid), 0);
        @(negedge clk); rst = 1'b0;
        // CPU store
        @(negedge clk); cpu(1, 1, 32'h10, 32'hDEADBEEF); #1;
        chk("st_mem_we", 32'(mem_we), 1);
        chk("st_mem_addr", mem_addr, 32'h10);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_stall", 32'(cpu_stall), 0);
        @(negedge clk); cpu(0, 0, 0, 0); #1;
        chk("st_we_drop", 32'(mem_we), 0);
        chk("idle_addr", mem_addr, 0);
        // CPU load, RD_LAT=1
        @(negedge clk); cpu(1, 0, 32'h10, 0); #1;
        chk("ld_stall1", 32'(cpu_stall), 1);
        chk("ld_addr", mem_addr, 32'h10);
        chk("ld_we", 32'(mem_we), 0);
        @(negedge clk); #1;
        chk("ld_stall0", 32'(cpu_stall), 0);
        chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("ld_hold_addr", mem_addr, 32'h10);
        // Ext write then read
        @(negedge clk); cpu(0, 0, 0, 0); ext(1, 1, 32'h20, 32'h12345678); #1;
        chk("ew_ack", 32'(ext_ack), 1);
        chk("ew_we", 32'(mem_we), 1);
        chk("ew_addr", mem_addr, 32'h20);
        chk("ew_wdata", mem_wdata, 32'h12345678);
        @(negedge clk); ext(1, 0, 32'h20, 0); #1;
        chk("er_ack", 32'(ext_ack), 1);
        chk("er_rvalid_early", 32'(ext_rvalid), 0);
        chk("er_we", 32'(mem_we), 0);
        @(negedge clk); ext(0, 0, 0, 0); #1;
        chk("er_rvalid", 32'(ext_rvalid), 1);
        chk("er_rdata", ext_rdata, 32'h12345678);
        chk("er_ack_low", 32'(ext_ack), 0);
        @(negedge clk); #1;
        chk("er_rvalid_pulse", 32'(ext_rvalid), 0);
        // Tie after reset: CPU first, then alternate
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); cpu(1, 0, 32'h10, 0); ext(1, 0, 32'h20, 0); #1;
        chk("tie_cpu_stall", 32'(cpu_stall), 1);
        chk("tie_ext_ack0", 32'(ext_ack), 0);
        chk("tie_addr_cpu", mem_addr, 32'h10);
        @(negedge clk); #1;
        chk("tie_cpu_ret", 32'(cpu_stall), 0);
        chk("tie_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("tie_no_ack_ret", 32'(ext_ack), 0);
        @(negedge clk); #1;
        chk("tie_ext_ack1", 32'(ext_ack), 1);
        chk("tie_cpu_wait", 32'(cpu_stall), 1);
        chk("tie_addr_ext", mem_addr, 32'h20);
        @(negedge clk); #1;
        chk("tie_ext_rvalid", 32'(ext_rvalid), 1);
        chk("tie_ext_rdata", ext_rdata, 32'h12345678);
        chk("tie_cpu_wait2", 32'(cpu_stall), 1);
        @(negedge clk); #1;
        chk("tie_cpu_again", mem_addr, 32'h10);
        chk("tie_ext_lose", 32'(ext_ack), 0);
        chk("tie_cpu_stall3", 32'(cpu_stall), 1);
        @(negedge clk); #1;
        chk("tie_cpu_ret2", 32'(cpu_stall), 0);
        chk("tie_cpu_rdata2", cpu_rdata, 32'hDEADBEEF);
        @(negedge clk); cpu(0, 0, 0, 0); ext(0, 0, 0, 0); #1;
        chk("tie_idle", mem_addr, 0);
        // CPU flushed during RD_WAIT
        @(negedge clk); cpu(1, 0, 32'h10, 0); #1;
        chk("fl_stall", 32'(cpu_stall), 1);
        @(negedge clk); cpu(0, 0, 0, 0); #1;
        chk("fl_no_stall", 32'(cpu_stall), 0);
        chk("fl_hold_addr", mem_addr, 32'h10);
        @(negedge clk); #1;
        chk("fl_idle_addr", mem_addr, 0);
        @(negedge clk); ext(1, 1, 32'h30, 32'hA5A5A5A5); #1;
        chk("fl_next_ack", 32'(ext_ack), 1);
        chk("fl_next_we", 32'(mem_we), 1);
        // Reset during RD_WAIT of an ext read
        @(negedge clk); ext(1, 0, 32'h20, 0); #1;
        chk("ra_ack", 32'(ext_ack), 1);
        @(negedge clk); ext(0, 0, 0, 0); rst = 1'b1; #1;
        chk("ra_rvalid", 32'(ext_rvalid), 0);
        chk("ra_addr", mem_addr, 0);
        chk("ra_rdata", ext_rdata, 0);
        chk("ra_ack0", 32'(ext_ack), 0);
        @(negedge clk); rst = 1'b0; cpu(1, 1, 32'h40, 32'h55); #1;
        chk("ra_cpu_we", 32'(mem_we), 1);
        chk("ra_cpu_addr", mem_addr, 32'h40);
        chk("ra_cpu_stall", 32'(cpu_stall), 0);
        chk("ra_no_rvalid", 32'(ext_rvalid), 0);
        @(negedge clk); cpu(0, 0, 0, 0); #1;
        chk("ra_no_rvalid2", 32'(ext_rvalid), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
